entry_sequencer: RTL and testbench



---
 rtl/calc_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/entry_sequencer.sv | 103 ++++++++++
 tb/tb_entry_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared state definitions for the calculator front end and display stage.
package calc_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_A    = 3'd0;
  localparam logic [STATE_W-1:0] ST_OP   = 3'd1;
  localparam logic [STATE_W-1:0] ST_B    = 3'd2;
  localparam logic [STATE_W-1:0] ST_CALC = 3'd3;
  localparam logic [STATE_W-1:0] ST_SHOW = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_A    = ST_A,
    S_OP   = ST_OP,
    S_B    = ST_B,
    S_CALC = ST_CALC,
    S_SHOW = ST_SHOW
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-FF synchronizer, stability counter, accepted level
// and a registered one-cycle pulse on the accepted rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count only while a change is pending; any return to the accepted level restarts.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/entry_sequencer.sv
// Operand/operator entry sequencer: debounced confirm/clear buttons drive the
// A -> OP -> B -> CALC -> SHOW walk and the latch-stage enables.
module entry_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_confirm,
  input  logic               btn_clear,
  output logic               en_a,
  output logic               en_op,
  output logic               en_b,
  output logic               latch_clr,
  output logic               calc_valid,
  output logic               show_result,
  output logic [STATE_W-1:0] state
);

  logic   confirm_press, clear_press;
  state_e state_q, state_d;
  logic   clr_d;
  logic   latch_clr_q, en_a_q, en_op_q, en_b_q, calc_valid_q, show_result_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_confirm (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_confirm),
    .press(confirm_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_clear (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_clear),
    .press(clear_press)
  );

  // Next state; clear has priority over confirm.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (clear_press) begin
      state_d = S_A;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        S_A:    if (confirm_press) state_d = S_OP;
        S_OP:   if (confirm_press) state_d = S_B;
        S_B:    if (confirm_press) state_d = S_CALC;
        S_CALC: state_d = S_SHOW;
        S_SHOW: begin
          if (confirm_press) begin
            state_d = S_A;
            clr_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_A;
          clr_d   = 1'b1;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_A;
      latch_clr_q   <= 1'b1;
      en_a_q        <= 1'b1;
      en_op_q       <= 1'b0;
      en_b_q        <= 1'b0;
      calc_valid_q  <= 1'b0;
      show_result_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      latch_clr_q   <= clr_d;
      en_a_q        <= (state_d == S_A);
      en_op_q       <= (state_d == S_OP);
      en_b_q        <= (state_d == S_B);
      calc_valid_q  <= (state_d == S_CALC);
      show_result_q <= (state_d == S_SHOW);
    end
  end

  assign state       = state_q;
  assign latch_clr   = latch_clr_q;
  assign en_a        = en_a_q;
  assign en_op       = en_op_q;
  assign en_b        = en_b_q;
  assign calc_valid  = calc_valid_q;
  assign show_result = show_result_q;

endmodule

// File: tb/tb_entry_sequencer.sv
// Directed bench for entry_sequencer with a short debounce window.
module tb_entry_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_confirm;
  logic       btn_clear;
  logic       en_a, en_op, en_b, latch_clr, calc_valid, show_result;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int cv_cnt, cv_in3, lc_cnt, moves, onehot_bad;
  logic saw_b;
  logic [2:0] prev_st;

  entry_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_confirm(btn_confirm),
    .btn_clear  (btn_clear),
    .en_a       (en_a),
    .en_op      (en_op),
    .en_b       (en_b),
    .latch_clr  (latch_clr),
    .calc_valid (calc_valid),
    .show_result(show_result),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the edge and update monitors.
  task automatic tick();
    @(posedge clk);
    #1;
    if (calc_valid === 1'b1) cv_cnt++;
    if (calc_valid === 1'b1 && state === 3'd3) cv_in3++;
    if (latch_clr === 1'b1) lc_cnt++;
    if (state === 3'd2) saw_b = 1'b1;
    if (state !== prev_st) moves++;
    prev_st = state;
    if ($countones({en_a, en_op, en_b, calc_valid, show_result}) > 1) onehot_bad++;
  endtask

  // Clean confirm press held 10 cycles, then released and allowed to settle.
  task automatic confirm_press();
    btn_confirm = 1'b1;
    repeat (10) tick();
    btn_confirm = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    reset = 1'b1; btn_confirm = 1'b0; btn_clear = 1'b0;
    cv_cnt = 0; cv_in3 = 0; lc_cnt = 0; moves = 0; onehot_bad = 0;
    saw_b = 1'b0; prev_st = 3'd0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_clr", 32'(latch_clr), 32'd1);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_en_a", 32'(en_a), 32'd1);
    end
    reset = 1'b0;
    tick();
    chk("post_rst_clr", 32'(latch_clr), 32'd0);
    chk("post_rst_outs", 32'({en_a, en_op, en_b, calc_valid, show_result}), 32'b10000);

    // First press: 2 sync + 4 debounce + 1 edge detect, state moves one edge later
    moves = 0;
    btn_confirm = 1'b1;
    repeat (7) tick();
    chk("lat_pre", 32'(state), 32'd0);
    tick();
    chk("lat_post", 32'(state), 32'd1);
    chk("op_en", 32'({en_a, en_op}), 32'b01);
    repeat (2) tick();
    btn_confirm = 1'b0;
    repeat (10) tick();
    chk("release_nomove", 32'(state), 32'd1);

    confirm_press();
    chk("to_b", 32'(state), 32'd2);
    chk("en_b", 32'(en_b), 32'd1);

    cv_cnt = 0; cv_in3 = 0;
    confirm_press();
    chk("to_show", 32'(state), 32'd4);
    chk("show_result", 32'(show_result), 32'd1);
    chk("cv_width", 32'(cv_cnt), 32'd1);
    chk("cv_in_calc", 32'(cv_in3), 32'd1);

    lc_cnt = 0;
    confirm_press();
    chk("wrap_state", 32'(state), 32'd0);
    chk("wrap_clr", 32'(lc_cnt), 32'd1);
    chk("wrap_en_a", 32'(en_a), 32'd1);
    chk("seq_moves", 32'(moves), 32'd5);

    // Bounce: toggle every 2 cycles for 20 cycles
    moves = 0;
    for (int i = 0; i < 10; i++) begin
      btn_confirm = ~btn_confirm;
      tick();
      tick();
    end
    chk("bounce_moves", 32'(moves), 32'd0);
    btn_confirm = 1'b1;
    repeat (12) tick();
    chk("bounce_state", 32'(state), 32'd1);
    repeat (10) tick();
    chk("held_one_press", 32'(moves), 32'd1);
    btn_confirm = 1'b0;
    repeat (10) tick();

    // Clear mid-entry from S_B
    confirm_press();
    chk("pre_clear_b", 32'(state), 32'd2);
    btn_clear = 1'b1;
    repeat (7) tick();
    chk("clear_pre", 32'(state), 32'd2);
    tick();
    chk("clear_state", 32'(state), 32'd0);
    chk("clear_en", 32'({en_a, en_b}), 32'b10);
    chk("clear_clr", 32'(latch_clr), 32'd1);
    tick();
    chk("clear_clr_end", 32'(latch_clr), 32'd0);
    btn_clear = 1'b0;
    repeat (10) tick();

    // Simultaneous confirm and clear in S_OP
    confirm_press();
    chk("pre_sim_op", 32'(state), 32'd1);
    saw_b = 1'b0; lc_cnt = 0;
    btn_confirm = 1'b1; btn_clear = 1'b1;
    repeat (10) tick();
    btn_confirm = 1'b0; btn_clear = 1'b0;
    repeat (10) tick();
    chk("sim_state", 32'(state), 32'd0);
    chk("sim_no_b", 32'(saw_b), 32'd0);
    chk("sim_clr", 32'(lc_cnt), 32'd1);

    // Reset while the confirm counter is at 2
    btn_confirm = 1'b1;
    repeat (4) tick();
    reset = 1'b1; btn_confirm = 1'b0;
    repeat (2) tick();
    chk("mid_rst_clr", 32'(latch_clr), 32'd1);
    reset = 1'b0;
    moves = 0;
    repeat (20) tick();
    chk("mid_rst_nomove", 32'(moves), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    confirm_press();
    chk("fresh_press", 32'(state), 32'd1);

    chk("onehot", 32'(onehot_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
